// File: rtl/iter_muldiv.sv
// iter_muldiv: multi-cycle RV64M multiply/divide unit (shift-add, restoring divide).
// Optional MULDIV_EARLY_OUT_EN: trivial operands skip the iteration phase.
module iter_muldiv #(
   parameter int XLEN = 64,
   parameter int OPW  = 8,
   parameter int TAGW = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OPW-1:0]  in_op,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [TAGW-1:0] in_tag,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic [TAGW-1:0] out_tag,
   output logic            out_illegal
);

   localparam int CW = $clog2(XLEN + 1);
   localparam int PW = 2 * XLEN;
   localparam logic [31:0] W_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t state;

   logic d_legal, d_mul, d_hi, d_sa, d_sb, d_rem, d_w;
   logic [XLEN-1:0] ax, bx, a_mag, b_mag, min_v;
   logic a_neg, b_neg, d_dz, d_ovf, early;
   logic [CW-1:0] n_in;

   logic r_mul, r_hi, r_rem, r_w, r_pneg, r_aneg, r_dz, r_ovf;
   logic [XLEN-1:0] ax_r, a_r, b_r;
   logic [PW-1:0] mc_r, acc_r;
   logic [TAGW-1:0] tag_r;
   logic [CW-1:0] cnt, lim;

   logic [XLEN+1:0] diff;
   logic [XLEN:0] rs;
   logic ge;
   logic [PW-1:0] prod;
   logic [XLEN-1:0] quo, rem, res;

   assign in_ready = (state == IDLE);

   // opcode decode into operation class and signedness
   always_comb begin
      d_legal = 1'b1;
      d_mul = 1'b0;
      d_hi = 1'b0;
      d_sa = 1'b0;
      d_sb = 1'b0;
      d_rem = 1'b0;
      d_w = 1'b0;
      case (in_op)
         OPW'(10): d_mul = 1'b1;
         OPW'(11): begin
            d_mul = 1'b1; d_hi = 1'b1;
            d_sa = 1'b1; d_sb = 1'b1;
         end
         OPW'(12): begin
            d_mul = 1'b1; d_hi = 1'b1;
            d_sa = 1'b1;
         end
         OPW'(13): begin
            d_mul = 1'b1; d_hi = 1'b1;
         end
         OPW'(14): begin
            d_sa = 1'b1; d_sb = 1'b1;
         end
         OPW'(15): d_legal = 1'b1;
         OPW'(16): begin
            d_sa = 1'b1; d_sb = 1'b1;
            d_rem = 1'b1;
         end
         OPW'(17): d_rem = 1'b1;
         OPW'(38): begin
            d_mul = 1'b1; d_w = 1'b1;
         end
         OPW'(39): begin
            d_w = 1'b1;
            d_sa = 1'b1; d_sb = 1'b1;
         end
         OPW'(40): d_w = 1'b1;
         OPW'(41): begin
            d_w = 1'b1; d_rem = 1'b1;
            d_sa = 1'b1; d_sb = 1'b1;
         end
         OPW'(42): begin
            d_w = 1'b1; d_rem = 1'b1;
         end
         default: d_legal = 1'b0;
      endcase
      if (d_w && XLEN != 64) d_legal = 1'b0;
   end

   // operand widening, magnitudes and special-case detection
   always_comb begin
      ax = in_rs1;
      bx = in_rs2;
      if (d_w) begin
         ax = d_sa ? XLEN'($signed(in_rs1[31:0])) : XLEN'(in_rs1[31:0]);
         bx = d_sb ? XLEN'($signed(in_rs2[31:0])) : XLEN'(in_rs2[31:0]);
      end
      a_neg = d_sa & ax[XLEN-1];
      b_neg = d_sb & bx[XLEN-1];
      a_mag = a_neg ? -ax : ax;
      b_mag = b_neg ? -bx : bx;
      min_v = d_w ? XLEN'($signed(W_MIN)) : {1'b1, {(XLEN-1){1'b0}}};
      d_dz = !d_mul && (bx == '0);
      d_ovf = !d_mul && d_sa && (ax == min_v) && (bx == '1);
      n_in = d_w ? CW'(32) : CW'(XLEN);
   end

   // decide whether the iteration phase can be skipped
   always_comb begin
      early = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
      early = d_mul ? ((ax == '0) || (bx == '0)) : (d_dz || d_ovf);
`endif
   end

   // restoring-divide step and final sign fix-up
   always_comb begin
      lim = r_w ? CW'(32) : CW'(XLEN);
      rs = {acc_r[XLEN-1:0], a_r[XLEN-1]};
      diff = {1'b0, rs} - {2'b00, b_r};
      ge = !diff[XLEN+1];
      prod = r_pneg ? -acc_r : acc_r;
      quo = r_pneg ? -a_r : a_r;
      rem = r_aneg ? -acc_r[XLEN-1:0] : acc_r[XLEN-1:0];
      if (r_dz) begin
         quo = '1;
         rem = ax_r;
      end
      if (r_ovf) begin
         quo = ax_r;
         rem = '0;
      end
      if (r_mul) res = r_hi ? prod[PW-1:XLEN] : prod[XLEN-1:0];
      else res = r_rem ? rem : quo;
      if (r_w) res = XLEN'($signed(res[31:0]));
   end

   // control FSM, operand capture, iteration and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         out_valid <= 1'b0;
         out_result <= '0;
         out_tag <= '0;
         out_illegal <= 1'b0;
         r_mul <= 1'b0;
         r_hi <= 1'b0;
         r_rem <= 1'b0;
         r_w <= 1'b0;
         r_pneg <= 1'b0;
         r_aneg <= 1'b0;
         r_dz <= 1'b0;
         r_ovf <= 1'b0;
         ax_r <= '0;
         a_r <= '0;
         b_r <= '0;
         mc_r <= '0;
         acc_r <= '0;
         tag_r <= '0;
         cnt <= '0;
      end else if (flush) begin
         state <= IDLE;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  tag_r <= in_tag;
                  if (!d_legal) begin
                     state <= DONE;
                     out_valid <= 1'b1;
                     out_result <= '0;
                     out_tag <= in_tag;
                     out_illegal <= 1'b1;
                  end else begin
                     state <= d_mul ? MUL : DIV;
                     r_mul <= d_mul;
                     r_hi <= d_hi;
                     r_rem <= d_rem;
                     r_w <= d_w;
                     r_pneg <= a_neg ^ b_neg;
                     r_aneg <= a_neg;
                     r_dz <= d_dz;
                     r_ovf <= d_ovf;
                     ax_r <= ax;
                     if (!d_mul && d_w) a_r <= a_mag << (XLEN - 32);
                     else a_r <= a_mag;
                     b_r <= b_mag;
                     mc_r <= PW'(b_mag);
                     acc_r <= '0;
                     cnt <= early ? n_in : '0;
                  end
               end
            end
            MUL, DIV: begin
               if (cnt == lim) begin
                  state <= DONE;
                  out_valid <= 1'b1;
                  out_result <= res;
                  out_tag <= tag_r;
                  out_illegal <= 1'b0;
               end else begin
                  cnt <= cnt + CW'(1);
                  if (state == MUL) begin
                     if (a_r[0]) acc_r <= acc_r + mc_r;
                     mc_r <= mc_r << 1;
                     a_r <= a_r >> 1;
                  end else begin
                     acc_r[XLEN-1:0] <= ge ? diff[XLEN-1:0] : rs[XLEN-1:0];
                     a_r <= {a_r[XLEN-2:0], ge};
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iter_muldiv.sv
// tb_iter_muldiv: vector table, corner sequences and random ops vs a reference model.
// Latency expectations follow MULDIV_EARLY_OUT_EN when it is defined.
module tb_iter_muldiv;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_op = '0;
   logic [63:0] in_rs1 = '0;
   logic [63:0] in_rs2 = '0;
   logic [4:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_result;
   logic [4:0]  out_tag;
   logic        out_illegal;

   int checks = 0;
   int failures = 0;

`ifdef MULDIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

   iter_muldiv #(.XLEN(64), .OPW(8), .TAGW(5)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .flush(flush),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_op(in_op),
      .in_rs1(in_rs1),
      .in_rs2(in_rs2),
      .in_tag(in_tag),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_result(out_result),
      .out_tag(out_tag),
      .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
      logic        ill;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic bit legal(input logic [7:0] op);
      return (op >= 8'd10 && op <= 8'd17) || (op >= 8'd38 && op <= 8'd42);
   endfunction

   function automatic logic [63:0] model(input logic [7:0] op, input logic [63:0] a,
                                         input logic [63:0] b);
      logic [127:0] pa, pb, p;
      longint sa, sb;
      int wa, wb;
      logic [31:0] w;
      logic [63:0] r;
      sa = a;
      sb = b;
      wa = a[31:0];
      wb = b[31:0];
      r = '0;
      w = '0;
      case (op)
         8'd10: r = a * b;
         8'd11, 8'd12, 8'd13: begin
            pa = {64'h0, a};
            pb = {64'h0, b};
            if (op != 8'd13 && a[63]) pa = {64'hFFFF_FFFF_FFFF_FFFF, a};
            if (op == 8'd11 && b[63]) pb = {64'hFFFF_FFFF_FFFF_FFFF, b};
            p = pa * pb;
            r = p[127:64];
         end
         8'd14: begin
            if (b == 0) r = '1;
            else if (a == MIN64 && b == '1) r = a;
            else r = sa / sb;
         end
         8'd15: begin
            if (b == 0) r = '1;
            else r = a / b;
         end
         8'd16: begin
            if (b == 0) r = a;
            else if (a == MIN64 && b == '1) r = '0;
            else r = sa % sb;
         end
         8'd17: begin
            if (b == 0) r = a;
            else r = a % b;
         end
         8'd38: w = wa * wb;
         8'd39: begin
            if (wb == 0) w = '1;
            else if (a[31:0] == 32'h8000_0000 && wb == -1) w = a[31:0];
            else w = wa / wb;
         end
         8'd40: begin
            if (b[31:0] == 0) w = '1;
            else w = a[31:0] / b[31:0];
         end
         8'd41: begin
            if (wb == 0) w = a[31:0];
            else if (a[31:0] == 32'h8000_0000 && wb == -1) w = '0;
            else w = wa % wb;
         end
         8'd42: begin
            if (b[31:0] == 0) w = a[31:0];
            else w = a[31:0] % b[31:0];
         end
         default: r = '0;
      endcase
      if (op >= 8'd38 && op <= 8'd42) r = {{32{w[31]}}, w};
      return r;
   endfunction

   function automatic int exp_lat(input logic [7:0] op, input logic [63:0] a,
                                  input logic [63:0] b);
      bit w, ismul, sgn, az, bz, ovf;
      if (!legal(op)) return 0;
      w = (op >= 8'd38);
      ismul = (op <= 8'd13) || (op == 8'd38);
      sgn = (op == 8'd14) || (op == 8'd16) || (op == 8'd39) || (op == 8'd41);
      az = w ? (a[31:0] == 0) : (a == 0);
      bz = w ? (b[31:0] == 0) : (b == 0);
      ovf = sgn && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
                      : (a == MIN64 && b == '1));
      if (EARLY && (ismul ? (az || bz) : (bz || ovf))) return 1;
      return w ? 33 : 65;
   endfunction

   function automatic logic [63:0] rnd_opnd();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return '1;
         2: return MIN64;
         3: return 64'($urandom_range(0, 20));
         4: return -64'($urandom_range(1, 20));
         5: return {$urandom, 32'h8000_0000};
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic start(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] tg);
      in_valid = 1'b1;
      in_op = op;
      in_rs1 = a;
      in_rs2 = b;
      in_tag = tg;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_op = 8'($urandom);
      in_rs1 = {$urandom, $urandom};
      in_rs2 = {$urandom, $urandom};
      in_tag = 5'($urandom);
   endtask

   task automatic apply(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input logic ill, input string nm);
      logic [4:0] tg;
      logic [63:0] r;
      int lat;
      tg = 5'($urandom);
      start(op, a, b, tg);
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({nm, " result"}, out_result, exp);
      chk({nm, " illegal"}, 64'(out_illegal), 64'(ill));
      chk({nm, " tag"}, 64'(out_tag), 64'(tg));
      chk({nm, " latency"}, 64'(lat), 64'(exp_lat(op, a, b)));
      r = out_result;
      @(posedge clk);
      #1;
      chk({nm, " hold valid"}, 64'(out_valid), 64'd1);
      chk({nm, " hold result"}, out_result, r);
      chk({nm, " busy in done"}, 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({nm, " idle after"}, 64'(in_ready), 64'd1);
      chk({nm, " valid drop"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      logic [7:0] ops[14];
      logic [7:0] op;
      logic [63:0] a, b;
      int seen, n;

      ops = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17,
              8'd38, 8'd39, 8'd40, 8'd41, 8'd42, 8'd33};

      vt.push_back('{op:8'd10, a:64'd7, b:64'hFFFF_FFFF_FFFF_FFFD,
                     exp:64'hFFFF_FFFF_FFFF_FFEB, ill:1'b0});
      vt.push_back('{op:8'd13, a:'1, b:'1, exp:64'hFFFF_FFFF_FFFF_FFFE, ill:1'b0});
      vt.push_back('{op:8'd11, a:'1, b:'1, exp:64'd0, ill:1'b0});
      vt.push_back('{op:8'd14, a:64'hFFFF_FFFF_FFFF_FFEC, b:64'd6,
                     exp:64'hFFFF_FFFF_FFFF_FFFD, ill:1'b0});
      vt.push_back('{op:8'd16, a:64'hFFFF_FFFF_FFFF_FFEC, b:64'd6,
                     exp:64'hFFFF_FFFF_FFFF_FFFE, ill:1'b0});
      vt.push_back('{op:8'd15, a:64'd10, b:64'd0, exp:'1, ill:1'b0});
      vt.push_back('{op:8'd17, a:64'd10, b:64'd0, exp:64'd10, ill:1'b0});
      vt.push_back('{op:8'd14, a:MIN64, b:'1, exp:MIN64, ill:1'b0});
      vt.push_back('{op:8'd16, a:MIN64, b:'1, exp:64'd0, ill:1'b0});
      vt.push_back('{op:8'd39, a:64'h1_0000_0010, b:64'd4, exp:64'd4, ill:1'b0});
      vt.push_back('{op:8'd33, a:64'd5, b:64'd6, exp:64'd0, ill:1'b1});
      vt.push_back('{op:8'd12, a:'1, b:64'd2, exp:'1, ill:1'b0});
      vt.push_back('{op:8'd38, a:64'h7FFF_FFFF, b:64'd2,
                     exp:64'hFFFF_FFFF_FFFF_FFFE, ill:1'b0});
      vt.push_back('{op:8'd40, a:64'hFFFF_FFFF, b:64'd1, exp:'1, ill:1'b0});
      vt.push_back('{op:8'd41, a:64'hFFFF_FFF9, b:64'd0,
                     exp:64'hFFFF_FFFF_FFFF_FFF9, ill:1'b0});
      vt.push_back('{op:8'd39, a:64'h8000_0000, b:64'hFFFF_FFFF,
                     exp:64'hFFFF_FFFF_8000_0000, ill:1'b0});
      vt.push_back('{op:8'd42, a:64'h1_0000_0007, b:64'd5, exp:64'd2, ill:1'b0});
      vt.push_back('{op:8'd13, a:MIN64, b:64'd4, exp:64'd2, ill:1'b0});
      vt.push_back('{op:8'd10, a:64'd0, b:64'd123, exp:64'd0, ill:1'b0});

      repeat (3) @(posedge clk);
      #1;
      chk("reset in_ready", 64'(in_ready), 64'd1);
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset out_result", out_result, 64'd0);
      chk("reset out_tag", 64'(out_tag), 64'd0);
      chk("reset out_illegal", 64'(out_illegal), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vt[i]) apply(vt[i].op, vt[i].a, vt[i].b, vt[i].exp, vt[i].ill, $sformatf("vec%0d", i));

      start(8'd10, 64'd5, 64'd9, 5'd3);
      repeat (20) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush mul in_ready", 64'(in_ready), 64'd1);
      chk("flush mul out_valid", 64'(out_valid), 64'd0);
      seen = 0;
      repeat (80) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1;
      end
      chk("flush mul no result", 64'(seen), 64'd0);

      in_valid = 1'b1;
      flush = 1'b1;
      in_op = 8'd10;
      in_rs1 = 64'd3;
      in_rs2 = 64'd4;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush = 1'b0;
      chk("flush idle not accepted", 64'(in_ready), 64'd1);
      seen = 0;
      repeat (70) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1;
      end
      chk("flush idle no result", 64'(seen), 64'd0);

      start(8'd14, 64'd100, 64'd7, 5'd4);
      n = 0;
      while (!out_valid && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("pre-flush done result", out_result, 64'd14);
      flush = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      out_ready = 1'b0;
      chk("flush done out_valid", 64'(out_valid), 64'd0);
      chk("flush done in_ready", 64'(in_ready), 64'd1);

      start(8'd14, {$urandom, $urandom}, 64'd3, 5'd7);
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst in_ready", 64'(in_ready), 64'd1);
      chk("midrst out_valid", 64'(out_valid), 64'd0);
      chk("midrst out_result", out_result, 64'd0);
      chk("midrst out_tag", 64'(out_tag), 64'd0);
      chk("midrst out_illegal", 64'(out_illegal), 64'd0);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      seen = 0;
      repeat (70) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1;
      end
      chk("midrst no result", 64'(seen), 64'd0);

      for (int k = 0; k < 150; k++) begin
         op = ops[$urandom_range(0, 13)];
         a = rnd_opnd();
         b = rnd_opnd();
         apply(op, a, b, model(op, a, b), !legal(op), $sformatf("rand%0d op%0d", k, op));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
